// File: rtl/risc16.sv
// risc16: non-pipelined multicycle 16-bit CPU (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK)
// with a big-endian, byte-addressed single memory port.

module risc16_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_ra,
    input  logic [2:0]  i_rb,
    output logic [15:0] o_rdata_a,
    output logic [15:0] o_rdata_b,
    input  logic        i_we,
    input  logic [2:0]  i_wa,
    input  logic [15:0] i_wdata
);
    logic [15:0] register0, register1, register2, register3;
    logic [15:0] register4, register5, register6, register7;

    always_ff @(posedge clk) begin
        if (rst) begin
            register0 <= 16'h0000;
            register1 <= 16'h0000;
            register2 <= 16'h0000;
            register3 <= 16'h0000;
            register4 <= 16'h0000;
            register5 <= 16'h0000;
            register6 <= 16'h0000;
            register7 <= 16'h0000;
        end else if (i_we) begin
            case (i_wa)
                3'd0:    register0 <= i_wdata;
                3'd1:    register1 <= i_wdata;
                3'd2:    register2 <= i_wdata;
                3'd3:    register3 <= i_wdata;
                3'd4:    register4 <= i_wdata;
                3'd5:    register5 <= i_wdata;
                3'd6:    register6 <= i_wdata;
                default: register7 <= i_wdata;
            endcase
        end
    end

    always_comb begin
        o_rdata_a = register0;
        case (i_ra)
            3'd0:    o_rdata_a = register0;
            3'd1:    o_rdata_a = register1;
            3'd2:    o_rdata_a = register2;
            3'd3:    o_rdata_a = register3;
            3'd4:    o_rdata_a = register4;
            3'd5:    o_rdata_a = register5;
            3'd6:    o_rdata_a = register6;
            default: o_rdata_a = register7;
        endcase
    end

    always_comb begin
        o_rdata_b = register0;
        case (i_rb)
            3'd0:    o_rdata_b = register0;
            3'd1:    o_rdata_b = register1;
            3'd2:    o_rdata_b = register2;
            3'd3:    o_rdata_b = register3;
            3'd4:    o_rdata_b = register4;
            3'd5:    o_rdata_b = register5;
            3'd6:    o_rdata_b = register6;
            default: o_rdata_b = register7;
        endcase
    end
endmodule

module risc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic [15:0] addr,
    output logic        oe,
    output logic        we
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

    state_t      state, w_state_next;
    logic [15:0] pc, ir, treg1, treg2, rdr, wdr;
    logic [15:0] sbus1, sbus2, dbus;
    logic [15:0] r_alu;

    logic [4:0]  w_op, w_func;
    logic [2:0]  w_rd, w_rs;
    logic        w_is_r, w_is_st, w_is_ld, w_wr_en, w_take;
    logic [15:0] w_imm, w_target, w_rdata_a, w_rdata_b, w_wdata;
    logic        w_rf_we;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        logic signed [7:0]  s;
        logic signed [15:0] w;
        s = signed'(v);
        w = 16'(s);
        return w;
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        logic signed [10:0] s;
        logic signed [15:0] w;
        s = signed'(v);
        w = 16'(s);
        return w;
    endfunction

    function automatic logic [15:0] alu(input logic [4:0] op, input logic [4:0] fn,
                                        input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        res = a;
        if (op == 5'b00000) begin
            case (fn)
                5'b00001: res = b;
                5'b00010: res = ~b;
                5'b00011: res = a ^ b;
                5'b00100: res = a + b;
                5'b00101: res = a - b;
                5'b01000: res = {a[14:0], 1'b0};
                5'b01001: res = {1'b0, a[15:1]};
                5'b01010: res = a & b;
                5'b01011: res = a | b;
                default:  res = a;
            endcase
        end else begin
            case (op)
                5'b00100: res = a + b;
                5'b00101: res = b;
                5'b00110: res = a & b;
                5'b00111: res = a | b;
                5'b00001: res = b;
                default:  res = a;
            endcase
        end
        return res;
    endfunction

    function automatic logic r_func_writes(input logic [4:0] fn);
        case (fn)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10001: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign w_op    = ir[15:11];
    assign w_rd    = ir[10:8];
    assign w_rs    = ir[7:5];
    assign w_func  = ir[4:0];
    assign w_is_r  = (w_op == 5'b00000);
    assign w_is_st = w_is_r && (w_func == 5'b10000);
    assign w_is_ld = w_is_r && (w_func == 5'b10001);

    // Immediate is pre-formatted in DECODE so EXECUTE sees a uniform operand
    always_comb begin
        w_imm = 16'h0000;
        case (w_op)
            5'b00100:                               w_imm = sext8(ir[7:0]);
            5'b00101, 5'b00110, 5'b00111:           w_imm = {8'h00, ir[7:0]};
            5'b00001:                               w_imm = {ir[7:0], 8'h00};
            5'b10000, 5'b10001, 5'b10010, 5'b10011: w_imm = sext8(ir[7:0]);
            5'b11000:                               w_imm = sext11(ir[10:0]);
            default:                                w_imm = 16'h0000;
        endcase
    end

    always_comb begin
        w_wr_en = 1'b0;
        case (w_op)
            5'b00000:                               w_wr_en = r_func_writes(w_func);
            5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b00001:                     w_wr_en = 1'b1;
            default:                                w_wr_en = 1'b0;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (w_op)
            5'b10000: w_take = (treg1 != 16'h0000);
            5'b10001: w_take = (treg1 == 16'h0000);
            5'b10010: w_take = treg1[15];
            5'b10011: w_take = ~treg1[15];
            5'b11000: w_take = 1'b1;
            default:  w_take = 1'b0;
        endcase
    end

    // pc already holds the incremented value, and treg2 the sign-extended offset
    assign w_target = pc + treg2;
    assign sbus1    = treg1;
    assign sbus2    = treg2;
    assign dbus     = alu(w_op, w_func, sbus1, sbus2);
    assign w_wdata  = w_is_ld ? rdr : r_alu;
    assign w_rf_we  = (state == WRITEBACK) && w_wr_en && !rst;

    risc16_reg_file reg_file_inst (
        .clk       (clk),
        .rst       (rst),
        .i_ra      (w_rd),
        .i_rb      (w_rs),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_rf_we),
        .i_wa      (w_rd),
        .i_wdata   (w_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= w_state_next;
    end

    always_comb begin
        w_state_next = FETCH;
        case (state)
            FETCH:     w_state_next = DECODE;
            DECODE:    w_state_next = EXECUTE;
            EXECUTE:   w_state_next = MEMORY;
            MEMORY:    w_state_next = WRITEBACK;
            WRITEBACK: w_state_next = FETCH;
            default:   w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= 16'h0000;
            ir    <= 16'h0000;
            treg1 <= 16'h0000;
            treg2 <= 16'h0000;
            rdr   <= 16'h0000;
            wdr   <= 16'h0000;
            r_alu <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    ir <= din;
                    pc <= pc + 16'd2;
                end
                DECODE: begin
                    treg1 <= w_rdata_a;
                    treg2 <= w_is_r ? w_rdata_b : w_imm;
                end
                EXECUTE: begin
                    r_alu <= dbus;
                    if (w_is_st) wdr <= treg1;
                end
                MEMORY: begin
                    if (w_is_ld) rdr <= din;
                end
                WRITEBACK: begin
                    if (w_take) pc <= w_target;
                end
                default: ;
            endcase
        end
    end

    // Reset overrides the bus strobes so an aborted st never reaches memory
    always_comb begin
        addr = pc;
        oe   = 1'b0;
        we   = 1'b0;
        dout = wdr;
        if (!rst) begin
            case (state)
                FETCH:  oe = 1'b1;
                MEMORY: begin
                    if (w_is_ld) begin
                        addr = treg2;
                        oe   = 1'b1;
                    end else if (w_is_st) begin
                        addr = treg2;
                        we   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_risc16.sv
// Bench for risc16: byte memory model, small programs per feature, expected
// results queued when a program is loaded and popped when the CPU produces them.
module tb_risc16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din, dout, addr;
    logic        oe, we;

    logic [7:0]  mem [0:65535];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [31:0] st_exp[$];
    logic [31:0] wr_q[$];

    risc16 dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .addr (addr),
        .oe   (oe),
        .we   (we)
    );

    always #5 clk = ~clk;

    assign din = (oe === 1'b1) ? {mem[{addr[15:1], 1'b0}], mem[{addr[15:1], 1'b1}]} : 16'h0000;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc_r(input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] fn);
        return {5'b00000, rd, rs, fn};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] w);
        mem[{a[15:1], 1'b0}] = w[15:8];
        mem[{a[15:1], 1'b1}] = w[7:0];
    endtask

    // Memory captures dout whenever we is seen high before the rising edge
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            if (we === 1'b1) begin
                mem[{addr[15:1], 1'b0}] = dout[15:8];
                mem[{addr[15:1], 1'b1}] = dout[7:0];
                wr_q.push_back({addr, dout});
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        string s;
        clear_mem();
        put(16'h0000, enc_i(5'b00101, 3'd1, 8'h07));
        do_reset();
        cycle(5);
        n_tests++;
        if (dut.reg_file_inst.register1 !== 16'h0007) begin
            n_fail++; $display("FAIL reset_pre_r1: got %h expected 0007", dut.reg_file_inst.register1);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (oe !== 1'b0 || we !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: oe=%b we=%b expected 0/0", oe, we);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (dut.pc !== 16'h0000 || dut.ir !== 16'h0000 || dut.reg_file_inst.register1 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_clear: pc=%h ir=%h r1=%h expected 0000", dut.pc, dut.ir, dut.reg_file_inst.register1);
        end
        rst = 1'b0;
        #1;
        s = dut.state.name();
        n_tests++;
        if (s != "FETCH" || addr !== 16'h0000 || oe !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_fetch: state=%s addr=%h oe=%b expected FETCH 0000 1", s, addr, oe);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (dut.pc !== 16'h0002) begin
            n_fail++; $display("FAIL reset_pc_inc: got %h expected 0002", dut.pc);
        end
    endtask

    task automatic test_immediate();
        clear_mem();
        exp_q.delete();
        put(16'h0000, enc_i(5'b00101, 3'd1, 8'h05)); exp_q.push_back(16'h0005);
        put(16'h0002, enc_i(5'b00100, 3'd1, 8'hFF)); exp_q.push_back(16'h0004);
        put(16'h0004, enc_i(5'b00110, 3'd1, 8'h06)); exp_q.push_back(16'h0004);
        put(16'h0006, enc_i(5'b00111, 3'd1, 8'hF0)); exp_q.push_back(16'h00F4);
        put(16'h0008, enc_i(5'b00001, 3'd1, 8'h12)); exp_q.push_back(16'h1200);
        put(16'h000A, enc_i(5'b00100, 3'd1, 8'h7F)); exp_q.push_back(16'h127F);
        put(16'h000C, enc_i(5'b01110, 3'd1, 8'h33)); exp_q.push_back(16'h127F);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            logic [15:0] e;
            cycle(5);
            e = exp_q.pop_front();
            n_tests++;
            if (dut.reg_file_inst.register1 !== e) begin
                n_fail++; $display("FAIL imm_r1[%0d]: got %h expected %h", i, dut.reg_file_inst.register1, e);
            end
        end
    endtask

    task automatic test_alu();
        logic [15:0] prog[$];
        bit          chk[$];
        clear_mem();
        exp_q.delete();
        prog.push_back(enc_i(5'b00001, 3'd1, 8'h80)); chk.push_back(0);
        prog.push_back(enc_i(5'b00111, 3'd1, 8'h01)); chk.push_back(0);
        prog.push_back(enc_i(5'b00101, 3'd2, 8'h03)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b00100)); chk.push_back(1); exp_q.push_back(16'h8004);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b00101)); chk.push_back(1); exp_q.push_back(16'h7FFE);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd0, 5'b01000)); chk.push_back(1); exp_q.push_back(16'h0002);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd0, 5'b01001)); chk.push_back(1); exp_q.push_back(16'h4000);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b00010)); chk.push_back(1); exp_q.push_back(16'hFFFC);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b00011)); chk.push_back(1); exp_q.push_back(16'h8002);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b01010)); chk.push_back(1); exp_q.push_back(16'h0001);
        prog.push_back(enc_r(3'd3, 3'd1, 5'b00001)); chk.push_back(0);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b01011)); chk.push_back(1); exp_q.push_back(16'h8003);
        prog.push_back(enc_r(3'd3, 3'd2, 5'b11111)); chk.push_back(1); exp_q.push_back(16'h8003);
        for (int i = 0; i < prog.size(); i++) put(16'(2 * i), prog[i]);
        do_reset();
        for (int i = 0; i < prog.size(); i++) begin
            cycle(5);
            if (chk[i]) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                n_tests++;
                if (dut.reg_file_inst.register3 !== e) begin
                    n_fail++; $display("FAIL alu_r3[%0d]: got %h expected %h", i, dut.reg_file_inst.register3, e);
                end
            end
        end
        n_tests++;
        if (dut.reg_file_inst.register1 !== 16'h8001) begin
            n_fail++; $display("FAIL alu_r1_kept: got %h expected 8001", dut.reg_file_inst.register1);
        end
    endtask

    task automatic test_store();
        logic [31:0] e, o;
        clear_mem();
        wr_q.delete();
        st_exp.delete();
        put(16'h0000, enc_i(5'b00101, 3'd2, 8'h20));
        put(16'h0002, enc_i(5'b00001, 3'd3, 8'hAB));
        put(16'h0004, enc_i(5'b00111, 3'd3, 8'hCD));
        put(16'h0006, enc_r(3'd3, 3'd2, 5'b10000));
        st_exp.push_back({16'h0020, 16'hABCD});
        do_reset();
        cycle(18);
        n_tests++;
        if (we !== 1'b1 || addr !== 16'h0020 || dout !== 16'hABCD) begin
            n_fail++; $display("FAIL st_memory_bus: we=%b addr=%h dout=%h expected 1 0020 ABCD", we, addr, dout);
        end
        cycle(7);
        n_tests++;
        if (wr_q.size() != 1) begin
            n_fail++; $display("FAIL st_we_count: got %0d write cycles expected 1", wr_q.size());
        end
        if (wr_q.size() > 0) begin
            e = st_exp.pop_front();
            o = wr_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL st_write: got addr/data %h expected %h", o, e);
            end
        end
        n_tests++;
        if (mem[16'h0020] !== 8'hAB || mem[16'h0021] !== 8'hCD) begin
            n_fail++; $display("FAIL st_mem_bytes: got %h %h expected AB CD", mem[16'h0020], mem[16'h0021]);
        end
    endtask

    task automatic test_load();
        string s;
        logic [15:0] e;
        clear_mem();
        exp_q.delete();
        put(16'h0000, enc_i(5'b00101, 3'd2, 8'h20));
        put(16'h0002, enc_r(3'd4, 3'd2, 5'b10001));
        mem[16'h0020] = 8'hAB;
        mem[16'h0021] = 8'hCD;
        exp_q.push_back(16'hABCD);
        do_reset();
        cycle(8);
        s = dut.state.name();
        n_tests++;
        if (s != "MEMORY" || oe !== 1'b1 || we !== 1'b0 || addr !== 16'h0020) begin
            n_fail++; $display("FAIL ld_memory_bus: state=%s oe=%b we=%b addr=%h expected MEMORY 1 0 0020", s, oe, we, addr);
        end
        cycle(2);
        e = exp_q.pop_front();
        n_tests++;
        if (dut.reg_file_inst.register4 !== e) begin
            n_fail++; $display("FAIL ld_r4: got %h expected %h", dut.reg_file_inst.register4, e);
        end
    endtask

    task automatic run_branch(input string nm, input logic [15:0] pre_word, input bit use_pre,
                              input logic [15:0] br_word, input logic [15:0] exp_fetch);
        logic [15:0] e;
        clear_mem();
        exp_q.delete();
        if (use_pre) put(16'h000E, pre_word);
        put(16'h0010, br_word);
        exp_q.push_back(16'h0010);
        exp_q.push_back(exp_fetch);
        do_reset();
        cycle(40);
        e = exp_q.pop_front();
        n_tests++;
        if (addr !== e || oe !== 1'b1) begin
            n_fail++; $display("FAIL %s_at_branch: addr=%h oe=%b expected %h 1", nm, addr, oe, e);
        end
        cycle(5);
        e = exp_q.pop_front();
        n_tests++;
        if (addr !== e || oe !== 1'b1) begin
            n_fail++; $display("FAIL %s_next_fetch: addr=%h oe=%b expected %h 1", nm, addr, oe, e);
        end
    endtask

    task automatic test_branch();
        logic [15:0] e;
        run_branch("beqz_taken", 16'h0000, 0, enc_i(5'b10001, 3'd5, 8'h04), 16'h0016);
        run_branch("beqz_not",   enc_i(5'b00101, 3'd5, 8'h01), 1, enc_i(5'b10001, 3'd5, 8'h04), 16'h0012);
        run_branch("bnez_taken", enc_i(5'b00101, 3'd5, 8'h01), 1, enc_i(5'b10000, 3'd5, 8'h04), 16'h0016);
        run_branch("bmi_back",   enc_i(5'b00001, 3'd5, 8'h80), 1, enc_i(5'b10010, 3'd5, 8'hFC), 16'h000E);
        run_branch("bpl_not",    enc_i(5'b00001, 3'd5, 8'h80), 1, enc_i(5'b10011, 3'd5, 8'hFC), 16'h0012);
        clear_mem();
        exp_q.delete();
        put(16'h0022, {5'b11000, 11'h7FE});
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h0022);
        do_reset();
        cycle(85);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (addr !== e || oe !== 1'b1) begin
                n_fail++; $display("FAIL jump_self[%0d]: addr=%h oe=%b expected %h 1", i, addr, oe, e);
            end
            cycle(5);
        end
    endtask

    task automatic test_abort();
        string s;
        clear_mem();
        put(16'h0000, enc_i(5'b00101, 3'd1, 8'h55));
        put(16'h0002, enc_r(3'd1, 3'd6, 5'b10000));
        do_reset();
        cycle(4);
        rst = 1'b1;
        #1;
        n_tests++;
        if (oe !== 1'b0 || we !== 1'b0) begin
            n_fail++; $display("FAIL abort_wb_strobes: oe=%b we=%b expected 0/0", oe, we);
        end
        cycle(1);
        rst = 1'b0;
        #1;
        s = dut.state.name();
        n_tests++;
        if (dut.reg_file_inst.register1 !== 16'h0000 || s != "FETCH" || dut.pc !== 16'h0000) begin
            n_fail++; $display("FAIL abort_wb: r1=%h state=%s pc=%h expected 0000 FETCH 0000", dut.reg_file_inst.register1, s, dut.pc);
        end
        cycle(5);
        n_tests++;
        if (dut.reg_file_inst.register1 !== 16'h0055) begin
            n_fail++; $display("FAIL abort_rerun_r1: got %h expected 0055", dut.reg_file_inst.register1);
        end
        wr_q.delete();
        cycle(3);
        n_tests++;
        if (we !== 1'b1 || addr !== 16'h0000) begin
            n_fail++; $display("FAIL abort_st_armed: we=%b addr=%h expected 1 0000", we, addr);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL abort_st_we: got %b expected 0", we);
        end
        cycle(1);
        rst = 1'b0;
        #1;
        n_tests++;
        if (wr_q.size() != 0 || mem[16'h0000] !== 8'h29 || mem[16'h0001] !== 8'h55) begin
            n_fail++; $display("FAIL abort_st_mem: writes=%0d mem=%h%h expected 0 2955", wr_q.size(), mem[16'h0000], mem[16'h0001]);
        end
    endtask

    initial begin
        clear_mem();
        @(negedge clk);
        test_reset();
        test_immediate();
        test_alu();
        test_store();
        test_load();
        test_branch();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
